// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core front end: instruction field layout,
// type encodings and the fetch/decode state machine states.
package cpu_pkg;

    localparam logic [1:0] TYPE_LITERAL  = 2'b00;
    localparam logic [1:0] TYPE_REGISTER = 2'b01;
    localparam logic [3:0] HALT_OPCODE   = 4'hF;

    // Bit positions within the 16-bit instruction word
    localparam int unsigned OPC_MSB      = 15;
    localparam int unsigned OPC_LSB      = 12;
    localparam int unsigned TYPE_MSB     = 11;
    localparam int unsigned TYPE_LSB     = 10;
    localparam int unsigned RD_MSB       = 9;
    localparam int unsigned RD_LSB       = 8;
    localparam int unsigned LIT_MSB      = 7;
    localparam int unsigned LIT_LSB      = 0;
    localparam int unsigned RS_MSB       = 1;
    localparam int unsigned RS_LSB       = 0;
    localparam int unsigned RESERVED_BIT = 11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

endpackage

// File: rtl/instr_field_split.sv
// Combinational slicing of a 16-bit instruction word into its fields,
// plus detection of the halt opcode and the reserved instruction types.
module instr_field_split
    import cpu_pkg::*;
#(
    parameter logic [3:0] HALT_OPC = 4'hF
) (
    input  logic [15:0] instr,
    output logic [3:0]  opcode,
    output logic [1:0]  instr_type,
    output logic [1:0]  rd_addr,
    output logic [1:0]  rs_addr,
    output logic [7:0]  literal,
    output logic        is_halt,
    output logic        is_reserved
);

    always_comb begin
        opcode      = instr[OPC_MSB:OPC_LSB];
        instr_type  = instr[TYPE_MSB:TYPE_LSB];
        rd_addr     = instr[RD_MSB:RD_LSB];
        rs_addr     = instr[RS_MSB:RS_LSB];
        literal     = instr[LIT_MSB:LIT_LSB];
        is_halt     = (instr[OPC_MSB:OPC_LSB] == HALT_OPC);
        is_reserved = instr[RESERVED_BIT];
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: owns the PC, registers decoded instruction fields and
// handles stall, branch redirect and halt.
module fetch_decode #(
    parameter int unsigned                 PC_WIDTH    = 8,
    parameter int unsigned                 INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]         RESET_PC    = '0,
    parameter logic [3:0]                  HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   instr_valid,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [3:0]             opcode,
    output logic [1:0]             instructionType,
    output logic [1:0]             rd_addr,
    output logic [1:0]             rs_addr,
    output logic [7:0]             literalOrAddress,
    output logic                   decode_valid,
    output logic                   illegal,
    output logic                   halted
);

    import cpu_pkg::*;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [3:0]          opcode_q, opcode_d;
    logic [1:0]          type_q, type_d;
    logic [1:0]          rd_q, rd_d;
    logic [1:0]          rs_q, rs_d;
    logic [7:0]          lit_q, lit_d;
    logic                valid_q, valid_d;
    logic                illegal_q, illegal_d;
    logic                halted_q, halted_d;

    logic [3:0]          s_opcode;
    logic [1:0]          s_type, s_rd, s_rs;
    logic [7:0]          s_lit;
    logic                s_halt, s_reserved;

    instr_field_split #(
        .HALT_OPC (HALT_OPCODE)
    ) u_split (
        .instr       (instr_in[15:0]),
        .opcode      (s_opcode),
        .instr_type  (s_type),
        .rd_addr     (s_rd),
        .rs_addr     (s_rs),
        .literal     (s_lit),
        .is_halt     (s_halt),
        .is_reserved (s_reserved)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            opcode_q  <= '0;
            type_q    <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            lit_q     <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            type_q    <= type_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            lit_q     <= lit_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        type_d    = type_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        lit_d     = lit_q;
        valid_d   = valid_q;
        illegal_d = 1'b0;
        halted_d  = halted_q;

        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                // Branch beats stall: a redirect discards whatever is on instr_in
                if (branch_taken) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                end else if (stall) begin
                    valid_d = valid_q;
                end else if (!instr_valid) begin
                    valid_d = 1'b0;
                end else begin
                    opcode_d = s_opcode;
                    type_d   = s_type;
                    rd_d     = s_rd;
                    rs_d     = s_rs;
                    lit_d    = s_lit;
                    if (s_halt) begin
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else if (s_reserved) begin
                        valid_d   = 1'b0;
                        illegal_d = 1'b1;
                        pc_d      = pc_q + PC_WIDTH'(1);
                    end else begin
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_WIDTH'(1);
                    end
                end
            end
            HALTED: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc               = pc_q;
        opcode           = opcode_q;
        instructionType  = type_q;
        rd_addr          = rd_q;
        rs_addr          = rs_q;
        literalOrAddress = lit_q;
        decode_valid     = valid_q;
        illegal          = illegal_q;
        halted           = halted_q;
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed self-checking bench for fetch_decode with hand-computed expectations.
module tb_fetch_decode;

    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  pc;
    logic [3:0]  opcode;
    logic [1:0]  instructionType;
    logic [1:0]  rd_addr;
    logic [1:0]  rs_addr;
    logic [7:0]  literalOrAddress;
    logic        decode_valid;
    logic        illegal;
    logic        halted;

    int unsigned total = 0;
    int unsigned bad   = 0;

    fetch_decode #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (16),
        .RESET_PC    (8'h00),
        .HALT_OPCODE (4'hF)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_in         (instr_in),
        .instr_valid      (instr_valid),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .pc               (pc),
        .opcode           (opcode),
        .instructionType  (instructionType),
        .rd_addr          (rd_addr),
        .rs_addr          (rs_addr),
        .literalOrAddress (literalOrAddress),
        .decode_valid     (decode_valid),
        .illegal          (illegal),
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; instr_in = '0; instr_valid = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0;

        // Reset
        step();
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_dv", 32'(decode_valid), 0);
        chk("rst_ill", 32'(illegal), 0);
        chk("rst_halt", 32'(halted), 0);
        chk("rst_opc", 32'(opcode), 0);
        chk("rst_lit", 32'(literalOrAddress), 0);

        // IDLE cycle: word offered but not fetched
        rst = 1'b0; instr_valid = 1'b1; instr_in = 16'h1A55;
        step();
        chk("idle_pc", 32'(pc), 32'h00);
        chk("idle_dv", 32'(decode_valid), 0);
        chk("idle_opc", 32'(opcode), 0);

        // 1A55: type 10 reserved
        step();
        chk("r1_opc", 32'(opcode), 1);
        chk("r1_type", 32'(instructionType), 2);
        chk("r1_rd", 32'(rd_addr), 2);
        chk("r1_rs", 32'(rs_addr), 1);
        chk("r1_lit", 32'(literalOrAddress), 32'h55);
        chk("r1_ill", 32'(illegal), 1);
        chk("r1_dv", 32'(decode_valid), 0);
        chk("r1_pc", 32'(pc), 32'h01);

        // 2503: register type
        instr_in = 16'h2503;
        step();
        chk("r2_opc", 32'(opcode), 2);
        chk("r2_type", 32'(instructionType), 1);
        chk("r2_rd", 32'(rd_addr), 1);
        chk("r2_rs", 32'(rs_addr), 3);
        chk("r2_lit", 32'(literalOrAddress), 32'h03);
        chk("r2_dv", 32'(decode_valid), 1);
        chk("r2_ill", 32'(illegal), 0);
        chk("r2_pc", 32'(pc), 32'h02);

        // 2D03: bits[11:10]=11 reserved
        instr_in = 16'h2D03;
        step();
        chk("r3_type", 32'(instructionType), 3);
        chk("r3_ill", 32'(illegal), 1);
        chk("r3_dv", 32'(decode_valid), 0);
        chk("r3_pc", 32'(pc), 32'h03);

        // 3004: literal type
        instr_in = 16'h3004;
        step();
        chk("r4_opc", 32'(opcode), 3);
        chk("r4_type", 32'(instructionType), 0);
        chk("r4_lit", 32'(literalOrAddress), 32'h04);
        chk("r4_dv", 32'(decode_valid), 1);
        chk("r4_pc", 32'(pc), 32'h04);

        // Stall three cycles with a valid word offered
        stall = 1'b1; instr_in = 16'h4155;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_pc", 32'(pc), 32'h04);
            chk("st_opc", 32'(opcode), 3);
            chk("st_lit", 32'(literalOrAddress), 32'h04);
            chk("st_dv", 32'(decode_valid), 1);
        end
        stall = 1'b0;
        step();
        chk("rel_opc", 32'(opcode), 4);
        chk("rel_rd", 32'(rd_addr), 1);
        chk("rel_lit", 32'(literalOrAddress), 32'h55);
        chk("rel_pc", 32'(pc), 32'h05);
        chk("rel_dv", 32'(decode_valid), 1);

        // Branch and stall together: branch wins, word discarded
        branch_taken = 1'b1; branch_target = 8'h40; stall = 1'b1; instr_in = 16'h5000;
        step();
        chk("br_pc", 32'(pc), 32'h40);
        chk("br_dv", 32'(decode_valid), 0);
        chk("br_opc", 32'(opcode), 4);
        branch_taken = 1'b0; stall = 1'b0; instr_in = 16'h6177;
        step();
        chk("br_acc_opc", 32'(opcode), 6);
        chk("br_acc_lit", 32'(literalOrAddress), 32'h77);
        chk("br_acc_pc", 32'(pc), 32'h41);
        chk("br_acc_dv", 32'(decode_valid), 1);

        // Wrap FF -> 00
        branch_taken = 1'b1; branch_target = 8'hFF;
        step();
        chk("wr_br_pc", 32'(pc), 32'hFF);
        branch_taken = 1'b0; instr_in = 16'h7008;
        step();
        chk("wr_pc", 32'(pc), 32'h00);
        chk("wr_opc", 32'(opcode), 7);

        // Bubble between two accepts
        instr_in = 16'h1102;
        step();
        chk("bb1_dv", 32'(decode_valid), 1);
        chk("bb1_pc", 32'(pc), 32'h01);
        instr_valid = 1'b0;
        step();
        chk("bb2_dv", 32'(decode_valid), 0);
        chk("bb2_pc", 32'(pc), 32'h01);
        chk("bb2_opc", 32'(opcode), 1);
        instr_valid = 1'b1; instr_in = 16'h8203;
        step();
        chk("bb3_dv", 32'(decode_valid), 1);
        chk("bb3_pc", 32'(pc), 32'h02);
        chk("bb3_opc", 32'(opcode), 8);

        // Halt with reserved type bit set: halt takes priority
        instr_in = 16'hF800;
        step();
        chk("h_halt", 32'(halted), 1);
        chk("h_dv", 32'(decode_valid), 0);
        chk("h_ill", 32'(illegal), 0);
        chk("h_pc", 32'(pc), 32'h02);
        chk("h_opc", 32'(opcode), 32'hF);
        chk("h_type", 32'(instructionType), 2);
        branch_taken = 1'b1; branch_target = 8'h55; instr_in = 16'h2503;
        step();
        chk("hb_pc", 32'(pc), 32'h02);
        chk("hb_halt", 32'(halted), 1);
        chk("hb_opc", 32'(opcode), 32'hF);
        branch_taken = 1'b0;
        step();
        chk("hv_pc", 32'(pc), 32'h02);
        chk("hv_dv", 32'(decode_valid), 0);

        // Reset while branch and stall are asserted
        rst = 1'b1; branch_taken = 1'b1; stall = 1'b1;
        step();
        chk("rr_pc", 32'(pc), 32'h00);
        chk("rr_halt", 32'(halted), 0);
        chk("rr_dv", 32'(decode_valid), 0);
        chk("rr_opc", 32'(opcode), 0);

        // Plain halt word after fresh start
        rst = 1'b0; branch_taken = 1'b0; stall = 1'b0; instr_in = 16'hF000;
        step();
        chk("h2_idle_halt", 32'(halted), 0);
        step();
        chk("h2_halt", 32'(halted), 1);
        chk("h2_pc", 32'(pc), 32'h00);
        chk("h2_dv", 32'(decode_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
